conv_pool_writeback: RTL and testbench

Parametrised back end for the convolution/pool layers: accepts a stream of per-input-channel inner products, sums across channels, adds bias, applies saturating ReLU, performs 2x2 pooling per output kernel and writes pooled results to the feature-map buffer with kernel-major addressing. It sits between the per-channel inner-product sub-modules and the next layer's input RAM. It replaces the hard-wired 6-channel/16-kernel back end with configurable channel count, kernel count and output size, and adds backpressure and saturation.

---
 rtl/conv_pool_writeback_if.sv | 26 ++
 rtl/conv_pool_writeback.sv | 178 +++++++++++++++++
 tb/tb_conv_pool_writeback.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_writeback_if.sv
// Bus bundle for conv_pool_writeback: psum beat stream in, pooled writes out.
// master = upstream/feature-map-buffer side, slave = conv_pool_writeback.
interface conv_pool_writeback_if #(
    parameter int IN_CH  = 6,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_CH*DATA_W-1:0]   in_psum;
    logic [DATA_W-1:0]         in_bias;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    modport master (
        output in_valid, in_psum, in_bias, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_psum, in_bias, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/conv_pool_writeback.sv
// Conv/pool back end: channel sum + bias, saturating ReLU, 2x2 pooling, kernel-major writeback.
// Define CONV_POOL_AVG_POOL_EN for average pooling; max pooling otherwise.
module conv_pool_writeback #(
    parameter int IN_CH   = 6,
    parameter int OUT_CH  = 16,
    parameter int DATA_W  = 16,
    parameter int OUT_PIX = 25,
    parameter int ADDR_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic sat_seen,
    conv_pool_writeback_if.slave bus
);
    localparam int SUM_W = DATA_W + $clog2(IN_CH + 1);
    localparam int K_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int PIX_W = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
`ifdef CONV_POOL_AVG_POOL_EN
    localparam int BUF_W = DATA_W + 2;
`else
    localparam int BUF_W = DATA_W;
`endif
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nx;

    logic                      stall, accept, start_ok, last_beat;
    logic [K_W-1:0]            k;
    logic [1:0]                pos;
    logic [PIX_W-1:0]          pix;
    logic signed [SUM_W-1:0]   beat_sum;

    logic                      s1_valid;
    logic signed [SUM_W-1:0]   s1_sum;
    logic [K_W-1:0]            s1_k;
    logic [1:0]                s1_pos;
    logic [PIX_W-1:0]          s1_pix;

    logic [DATA_W-1:0]         relu_v;
    logic                      relu_sat;
    logic [BUF_W-1:0]          pool_buf [OUT_CH];
    logic [BUF_W-1:0]          pool_cur, pool_upd;
    logic [DATA_W-1:0]         pool_out;

    logic                      wr_valid;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    assign stall        = wr_valid && !bus.wr_ready;
    assign bus.in_ready = (state == RUN) && !stall;
    assign accept       = bus.in_valid && bus.in_ready;
    assign start_ok     = start && (state == IDLE);
    assign last_beat    = (pix == PIX_W'(OUT_PIX - 1)) && (pos == 2'd3)
                          && (k == K_W'(OUT_CH - 1));
    assign busy         = (state != IDLE);
    assign bus.wr_valid = wr_valid;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;

    always_comb begin
        beat_sum = {{(SUM_W-DATA_W){bus.in_bias[DATA_W-1]}}, bus.in_bias};
        for (int unsigned c = 0; c < IN_CH; c++) begin
            beat_sum = beat_sum + {{(SUM_W-DATA_W){bus.in_psum[c*DATA_W+DATA_W-1]}},
                                   bus.in_psum[c*DATA_W +: DATA_W]};
        end
    end

    always_comb begin
        relu_v   = '0;
        relu_sat = 1'b0;
        if (s1_sum[SUM_W-1]) begin
            relu_v = '0;
        end else if (s1_sum > SAT_MAX) begin
            relu_v   = {1'b0, {(DATA_W-1){1'b1}}};
            relu_sat = 1'b1;
        end else begin
            relu_v = s1_sum[DATA_W-1:0];
        end
    end

    // pool_upd is the running window value including this beat; pos 3 emits it without storing
    always_comb begin
        pool_cur = pool_buf[s1_k];
`ifdef CONV_POOL_AVG_POOL_EN
        pool_upd = pool_cur + BUF_W'(relu_v);
        pool_out = pool_upd[BUF_W-1:2];
`else
        pool_upd = (pool_cur >= relu_v) ? pool_cur : relu_v;
        pool_out = pool_upd;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (accept && last_beat) state_nx = FLUSH;
            FLUSH: if (!s1_valid && !wr_valid) begin
                state_nx = IDLE;
                done     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= '0;
            pos <= '0;
            pix <= '0;
        end else if (start_ok) begin
            k   <= '0;
            pos <= '0;
            pix <= '0;
        end else if (accept) begin
            if (k == K_W'(OUT_CH - 1)) begin
                k <= '0;
                if (pos == 2'd3) begin
                    pos <= '0;
                    pix <= (pix == PIX_W'(OUT_PIX - 1)) ? '0 : pix + 1'b1;
                end else begin
                    pos <= pos + 2'd1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_k     <= '0;
            s1_pos   <= '0;
            s1_pix   <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            sat_seen <= 1'b0;
            for (int unsigned i = 0; i < OUT_CH; i++) pool_buf[i] <= '0;
        end else begin
            if (start_ok) sat_seen <= 1'b0;
            if (!stall) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_sum <= beat_sum;
                    s1_k   <= k;
                    s1_pos <= pos;
                    s1_pix <= pix;
                end
                wr_valid <= s1_valid && (s1_pos == 2'd3);
                if (s1_valid) begin
                    if (relu_sat) sat_seen <= 1'b1;
                    case (s1_pos)
                        2'd0: pool_buf[s1_k] <= BUF_W'(relu_v);
                        2'd3: begin
                            wr_addr <= ADDR_W'(s1_k) * ADDR_W'(OUT_PIX) + ADDR_W'(s1_pix);
                            wr_data <= pool_out;
                        end
                        default: pool_buf[s1_k] <= pool_upd;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_pool_writeback.sv
// Self-checking bench for conv_pool_writeback: random beats against a per-window pooling model.
module tb_conv_pool_writeback;
    localparam int IN_CH   = 6;
    localparam int OUT_CH  = 16;
    localparam int DATA_W  = 16;
    localparam int OUT_PIX = 25;
    localparam int ADDR_W  = 16;
    localparam int NB      = OUT_PIX * 4 * OUT_CH;
    localparam int NW      = OUT_PIX * OUT_CH;
    localparam int MAXV    = 32767;

    logic clk = 1'b0;
    logic rst_n, start;
    logic busy, done, sat_seen;

    conv_pool_writeback_if #(.IN_CH(IN_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    conv_pool_writeback #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .DATA_W(DATA_W), .OUT_PIX(OUT_PIX), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .sat_seen(sat_seen),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data;} wr_t;
    wr_t exp_q[$];
    wr_t e;
    int  acc_q[$];
    int  st_ps [NB][IN_CH];
    int  st_bias [NB];
    int  exp_data [NW];
    bit  exp_sat;

    int  n_checks = 0, n_fail = 0;
    int  cyc = 0, rdy_mode = 0;
    bit  checking = 0;
    int  wr_cnt = 0, acc_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
    bit  held = 0, done_prev = 0;
    int  held_addr, held_data;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic int bidx(int pix, int pos, int k);
        return (pix * 4 + pos) * OUT_CH + k;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = ($urandom_range(3) != 0);
            default: bus.wr_ready = ((cyc % 40) >= 5);
        endcase
    end

    // Stimulus tables and expected pooled outputs, straight from the layer arithmetic
    task automatic build_pass(input int p);
        int win [4] = '{3, 9, -4, 7};
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < IN_CH; c++) begin
                case (p)
                    0:       st_ps[b][c] = 1;
                    1:       st_ps[b][c] = int'($urandom_range(6000)) - 3000;
                    2:       st_ps[b][c] = 28672;
                    default: st_ps[b][c] = int'($urandom_range(20000)) - 10000;
                endcase
            end
            case (p)
                0, 2:    st_bias[b] = 0;
                1:       st_bias[b] = int'($urandom_range(6000)) - 3000;
                default: st_bias[b] = int'($urandom_range(20000)) - 10000;
            endcase
        end
        if (p == 1) begin
            for (int pos = 0; pos < 4; pos++) begin
                for (int c = 0; c < IN_CH; c++) begin
                    st_ps[bidx(5, pos, 2)][c] = (c == 0) ? win[pos] : 0;
                    st_ps[bidx(0, pos, 3)][c] = (c == 0) ? -1 : 0;
                    st_ps[bidx(1, pos, 4)][c] = (c < 5) ? 5 : 0;
                end
                st_bias[bidx(5, pos, 2)] = 0;
                st_bias[bidx(0, pos, 3)] = 0;
                st_bias[bidx(1, pos, 4)] = -10;
            end
        end
        exp_sat = 0;
        exp_q.delete();
        for (int pix = 0; pix < OUT_PIX; pix++) begin
            for (int k = 0; k < OUT_CH; k++) begin
                int acc, mx, s, v, b;
                acc = 0;
                mx  = 0;
                for (int pos = 0; pos < 4; pos++) begin
                    b = bidx(pix, pos, k);
                    s = st_bias[b];
                    for (int c = 0; c < IN_CH; c++) s += st_ps[b][c];
                    if (s < 0) v = 0;
                    else if (s > MAXV) begin v = MAXV; exp_sat = 1; end
                    else v = s;
                    acc += v;
                    if (pos == 0 || v > mx) mx = v;
                end
`ifdef CONV_POOL_AVG_POOL_EN
                exp_data[k * OUT_PIX + pix] = acc >> 2;
`else
                exp_data[k * OUT_PIX + pix] = mx;
`endif
            end
        end
        for (int pix = 0; pix < OUT_PIX; pix++) begin
            for (int k = 0; k < OUT_CH; k++) begin
                exp_q.push_back('{addr: k * OUT_PIX + pix, data: exp_data[k * OUT_PIX + pix]});
            end
        end
    endtask

    task automatic do_reset();
        checking = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat_seen", sat_seen, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        acc_q.delete();
        checking = 1;
    endtask

    task automatic run_pass(input int p, input int mode, input bit gaps, input int abort_at);
        int d0, t;
        bit ok;
        build_pass(p);
        rdy_mode = mode;
        wr_cnt   = 0;
        acc_cnt  = 0;
        acc_q.delete();
        checking = 1;
        d0       = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("in_ready_after_start", bus.in_ready, 1);
        check("busy_after_start", busy, 1);
        check("sat_cleared_by_start", sat_seen, 0);
        for (int b = 0; b < NB; b++) begin
            if (gaps && $urandom_range(3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_bias  = DATA_W'(st_bias[b]);
            for (int c = 0; c < IN_CH; c++) bus.in_psum[c*DATA_W +: DATA_W] = DATA_W'(st_ps[b][c]);
            t = 0;
            forever begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk);
                #1;
                if (ok) break;
                t++;
                if (t > 200) begin
                    check("accept_timeout", t, 200);
                    finish_run();
                end
            end
            if (b == abort_at) begin
                do_reset();
                check("busy_after_reset", busy, 0);
                return;
            end
        end
        bus.in_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_seen", done_cnt - d0, 1);
        if (done_cnt == d0) finish_run();
        check("busy_after_done", busy, 0);
        check("sat_seen_end", sat_seen, exp_sat);
    endtask

    // Single compare process: writes vs scoreboard, stall hold, latency, done timing
    always @(negedge clk) begin
        if (!checking || !rst_n) begin
            held      = 0;
            done_prev = 0;
        end else begin
            if (held) begin
                check("hold_valid", bus.wr_valid, 1);
                check("hold_addr", bus.wr_addr, held_addr);
                check("hold_data", bus.wr_data, held_data);
            end
            if (bus.wr_valid && !held) begin
                check("write_has_beat", acc_q.size() > 0, 1);
                if (acc_q.size() > 0) begin
                    int a;
                    a = acc_q.pop_front();
                    if (rdy_mode == 0) check("latency", cyc - a, 2);
                end
            end
            if (bus.wr_valid && !bus.wr_ready) check("in_ready_stall", bus.in_ready, 0);
            if (bus.wr_valid && bus.wr_ready) begin
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.wr_addr, e.addr);
                    check("wr_data", bus.wr_data, e.data);
                end
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (((acc_cnt / OUT_CH) % 4) == 3) acc_q.push_back(cyc);
                acc_cnt++;
            end
            if (done_prev) check("done_pulse", done, 0);
            if (done) begin
                check("done_gap", cyc - last_wr_cyc, 1);
                check("write_count", wr_cnt, NW);
                check("writes_left", exp_q.size(), 0);
                done_cnt++;
            end
            done_prev = done;
            held      = bus.wr_valid && !bus.wr_ready;
            held_addr = bus.wr_addr;
            held_data = bus.wr_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_fail++;
        finish_run();
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_psum  = '0;
        bus.in_bias  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sat_seen", sat_seen, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_wr_valid", bus.wr_valid, 0);
        check("reset_wr_addr", bus.wr_addr, 0);
        check("reset_wr_data", bus.wr_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_pass(0, 0, 0, -1);
        check("model_ones_first", exp_data[0], 6);
        check("model_ones_last", exp_data[NW-1], 6);

        run_pass(1, 2, 0, -1);
`ifdef CONV_POOL_AVG_POOL_EN
        check("model_window_55", exp_data[55], 4);
`else
        check("model_window_55", exp_data[55], 9);
`endif
        check("model_neg_sum", exp_data[75], 0);
        check("model_bias_sub", exp_data[101], 15);

        run_pass(2, 1, 1, -1);
        check("model_sat_value", exp_data[0], MAXV);
        check("model_sat_flag", exp_sat, 1);

        run_pass(3, 1, 1, 700);
        @(posedge clk);
        #1;
        run_pass(4, 1, 1, -1);
        run_pass(0, 0, 0, -1);

        finish_run();
    end
endmodule
